// File: rtl/vce2_pkg.sv
// Shared types and constants for the vce2 vector unit: the VRF sequencer state
// encoding plus the VRF read latency and address-generator load time.
package vce2_pkg;

  typedef enum logic [2:0] {
    VS_IDLE     = 3'd0,
    VS_LOAD     = 3'd1,
    VS_AGU_WAIT = 3'd2,
    VS_RD_A     = 3'd3,
    VS_RD_B     = 3'd4,
    VS_OP       = 3'd5,
    VS_RES      = 3'd6,
    VS_DONE     = 3'd7
  } vrf_seq_state_e;

  localparam int unsigned VRF_RD_LATENCY  = 1;
  localparam int unsigned AGU_LOAD_CYCLES = 3;

endpackage

// File: rtl/vce2_sat_cnt.sv
// Saturating up-counter used for the optional sequencer performance counters
// (only built when VCE2_VRF_SEQ_PERF_EN is defined).
`ifdef VCE2_VRF_SEQ_PERF_EN
module vce2_sat_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/vce2_vrf_seq.sv
// VRF sequencer: reads rs1/rs2 per word, hands operands to the lane ALU and
// writes the result to rd. Optional perf counters under VCE2_VRF_SEQ_PERF_EN.
module vce2_vrf_seq
  import vce2_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned VlWidth   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 vinstr_valid_i,
  output logic                 vinstr_ready_o,
  input  logic [VlWidth-1:0]   vl_i,
  input  logic                 two_src_i,
  output logic                 agu_load_o,
  input  logic                 agu_ready_i,
  output logic                 agu_get_rs1_o,
  output logic                 agu_get_rs2_o,
  output logic                 agu_get_rd_o,
  output logic                 agu_get_rd_noincr_o,
  output logic                 vrf_req_o,
  output logic                 vrf_we_o,
  output logic [DataWidth-1:0] vrf_wdata_o,
  input  logic [DataWidth-1:0] vrf_rdata_i,
  output logic                 op_valid_o,
  input  logic                 op_ready_i,
  output logic [DataWidth-1:0] op_a_o,
  output logic [DataWidth-1:0] op_b_o,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  input  logic [DataWidth-1:0] res_data_i,
  output logic                 done_o,
`ifdef VCE2_VRF_SEQ_PERF_EN
  output logic [31:0]          perf_busy_o,
  output logic [31:0]          perf_words_o,
`endif
  output logic [2:0]           dbg_state_o
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both
  // high; valid never depends on ready and the payload is held until transfer.

  vrf_seq_state_e state_q, state_d;
  logic [VlWidth-1:0]   remaining_q, remaining_d;
  logic                 two_src_q, two_src_d;
  logic [DataWidth-1:0] op_a_q, op_a_d;
  logic [DataWidth-1:0] op_b_q, op_b_d;
  logic                 op_fwd_q, op_fwd_d;
  logic                 res_fire;

  assign res_fire = (state_q == VS_RES) && res_valid_i;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    two_src_d   = two_src_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_fwd_d    = 1'b0;
    case (state_q)
      VS_IDLE: begin
        if (vinstr_valid_i) begin
          remaining_d = vl_i;
          two_src_d   = two_src_i;
          state_d     = (vl_i == '0) ? VS_DONE : VS_LOAD;
        end
      end
      VS_LOAD:     state_d = VS_AGU_WAIT;
      VS_AGU_WAIT: if (agu_ready_i) state_d = VS_RD_A;
      VS_RD_A: begin
        op_fwd_d = !two_src_q;
        state_d  = two_src_q ? VS_RD_B : VS_OP;
      end
      VS_RD_B: begin
        op_a_d   = vrf_rdata_i;
        op_fwd_d = 1'b1;
        state_d  = VS_OP;
      end
      VS_OP: begin
        if (op_fwd_q) begin
          if (two_src_q) begin
            op_b_d = vrf_rdata_i;
          end else begin
            op_a_d = vrf_rdata_i;
            op_b_d = '0;
          end
        end
        if (op_ready_i) state_d = VS_RES;
      end
      VS_RES: begin
        if (res_valid_i) begin
          remaining_d = remaining_q - VlWidth'(1);
          state_d     = (remaining_q == VlWidth'(1)) ? VS_DONE : VS_RD_A;
        end
      end
      VS_DONE: state_d = VS_IDLE;
      default: state_d = VS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= VS_IDLE;
      remaining_q <= '0;
      two_src_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_fwd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      two_src_q   <= two_src_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_fwd_q    <= op_fwd_d;
    end
  end

  // The last operand's read data only arrives in the first OP cycle, so it is
  // forwarded straight from the SRAM there and the captured copy held after.
  assign op_a_o = (op_fwd_q && !two_src_q) ? vrf_rdata_i : op_a_q;
  assign op_b_o = !two_src_q ? '0 : (op_fwd_q ? vrf_rdata_i : op_b_q);

  assign vinstr_ready_o      = (state_q == VS_IDLE);
  assign agu_load_o          = (state_q == VS_LOAD);
  assign agu_get_rs1_o       = (state_q == VS_RD_A);
  assign agu_get_rs2_o       = (state_q == VS_RD_B);
  assign agu_get_rd_o        = res_fire;
  assign agu_get_rd_noincr_o = 1'b0;
  assign vrf_req_o           = (state_q == VS_RD_A) || (state_q == VS_RD_B) || res_fire;
  assign vrf_we_o            = res_fire;
  assign vrf_wdata_o         = res_fire ? res_data_i : '0;
  assign op_valid_o          = (state_q == VS_OP);
  assign res_ready_o         = (state_q == VS_RES);
  assign done_o              = (state_q == VS_DONE);
  assign dbg_state_o         = state_q;

`ifdef VCE2_VRF_SEQ_PERF_EN
  vce2_sat_cnt #(.Width(32)) u_perf_busy (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (state_q != VS_IDLE),
    .count_o (perf_busy_o)
  );

  vce2_sat_cnt #(.Width(32)) u_perf_words (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (res_fire),
    .count_o (perf_words_o)
  );
`endif

endmodule

// File: tb/tb_vce2_vrf_seq.sv
// Bench for vce2_vrf_seq: models the address generator, VRF SRAM and lane ALU,
// and scoreboards operands and rd writes against a word-level reference.
`timescale 1ns/1ps
module tb_vce2_vrf_seq;
  import vce2_pkg::*;

  localparam int DW = 32;
  localparam int VW = 8;
  localparam int AW = 11;
  localparam int EW = AW + DW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          vinstr_valid_i = 1'b0;
  logic          vinstr_ready_o;
  logic [VW-1:0] vl_i = '0;
  logic          two_src_i = 1'b0;
  logic          agu_load_o;
  logic          agu_ready_i = 1'b0;
  logic          agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, agu_get_rd_noincr_o;
  logic          vrf_req_o, vrf_we_o;
  logic [DW-1:0] vrf_wdata_o;
  logic [DW-1:0] vrf_rdata_i = '0;
  logic          op_valid_o;
  logic          op_ready_i = 1'b0;
  logic [DW-1:0] op_a_o, op_b_o;
  logic          res_valid_i = 1'b0;
  logic          res_ready_o;
  logic [DW-1:0] res_data_i = '0;
  logic          done_o;
  logic [2:0]    dbg_state_o;
`ifdef VCE2_VRF_SEQ_PERF_EN
  logic [31:0]   perf_busy_o, perf_words_o;
`endif

  vce2_vrf_seq #(.DataWidth(DW), .VlWidth(VW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .vinstr_valid_i(vinstr_valid_i), .vinstr_ready_o(vinstr_ready_o),
    .vl_i(vl_i), .two_src_i(two_src_i),
    .agu_load_o(agu_load_o), .agu_ready_i(agu_ready_i),
    .agu_get_rs1_o(agu_get_rs1_o), .agu_get_rs2_o(agu_get_rs2_o),
    .agu_get_rd_o(agu_get_rd_o), .agu_get_rd_noincr_o(agu_get_rd_noincr_o),
    .vrf_req_o(vrf_req_o), .vrf_we_o(vrf_we_o),
    .vrf_wdata_o(vrf_wdata_o), .vrf_rdata_i(vrf_rdata_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_data_i(res_data_i),
    .done_o(done_o),
`ifdef VCE2_VRF_SEQ_PERF_EN
    .perf_busy_o(perf_busy_o), .perf_words_o(perf_words_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]   exp_q[$];     // {rd address, result} per word
  logic [2*DW-1:0] exp_op_q[$];  // {op_a, op_b} per word
  int n_cmp = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [0:2047];
  int rs1_base, rs2_base, rd_base;
  int rs1_p, rs2_p, rd_p;
  bit cur_two_src;
  int op_delay = 0;
  int res_delay = 0;

  int acc_cyc, first_load, first_req, done_cyc;
  int load_cnt, req_cnt, wr_cnt, rs2_cnt, done_cnt;
  logic [1:0] strobe_at [0:4095];

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a ^ 32'h5a5a_0f0f) + {b[DW-2:0], 1'b0} + 32'd7;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic clear_log();
    first_load = -1; first_req = -1; done_cyc = -1; acc_cyc = -1;
    load_cnt = 0; req_cnt = 0; wr_cnt = 0; rs2_cnt = 0;
    for (int i = 0; i < 4096; i++) strobe_at[i] = 2'd0;
  endtask

  // ---------------- environment models: AGU, VRF SRAM, lane ALU ----------------
  initial begin : responder
    int agu_cnt, op_wait, res_wait;
    bit res_pend, hs, do_load, do_rs1, do_rs2, do_wr;
    bit agur_nxt, opr_nxt, resv_nxt;
    logic [DW-1:0] res_val, rd_nxt, wd;
    agu_cnt = 0; op_wait = 0; res_wait = 0; res_pend = 0; res_val = '0;
    forever begin
      @(negedge clk_i);
      do_load = 0; do_rs1 = 0; do_rs2 = 0; do_wr = 0; wd = '0;
      rd_nxt = $urandom;
      if (!rst_ni) begin
        agu_cnt = 0; op_wait = 0; res_wait = 0; res_pend = 0;
      end else begin
        if (agu_load_o) begin
          do_load = 1; agu_cnt = 1;
        end else if (agu_cnt > 0 && agu_cnt < AGU_LOAD_CYCLES) begin
          agu_cnt++;
        end
        if (vrf_req_o && !vrf_we_o && agu_get_rs1_o) begin rd_nxt = mem[rs1_p]; do_rs1 = 1; end
        if (vrf_req_o && !vrf_we_o && agu_get_rs2_o) begin rd_nxt = mem[rs2_p]; do_rs2 = 1; end
        if (vrf_req_o && vrf_we_o && agu_get_rd_o) begin do_wr = 1; wd = vrf_wdata_o; end
        hs = op_valid_o && op_ready_i;
        if (hs) begin
          res_pend = 1; res_val = alu_f(op_a_o, op_b_o); res_wait = 0; op_wait = 0;
        end else if (op_valid_o) begin
          op_wait++;
        end
        if (res_valid_i && res_ready_o) res_pend = 0;
        else if (res_pend && !hs) res_wait++;
      end
      agur_nxt = rst_ni && (agu_cnt == AGU_LOAD_CYCLES);
      opr_nxt  = (op_delay == 0) || (op_wait >= op_delay);
      resv_nxt = rst_ni && res_pend && (res_wait >= res_delay);
      @(posedge clk_i);
      #1;
      agu_ready_i = agur_nxt;
      vrf_rdata_i = rd_nxt;
      op_ready_i  = opr_nxt;
      res_valid_i = resv_nxt;
      res_data_i  = resv_nxt ? res_val : $urandom;
      if (do_load) begin rs1_p = rs1_base; rs2_p = rs2_base; rd_p = rd_base; end
      if (do_rs1) rs1_p++;
      if (do_rs2) rs2_p++;
      if (do_wr) begin mem[rd_p] = wd; rd_p++; end
    end
  end

  // ---------------- monitor: pops and compares on DUT activity ----------------
  initial begin : monitor
    int ng;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (vinstr_valid_i && vinstr_ready_o) acc_cyc = cyc;
        if (agu_load_o) begin
          load_cnt++;
          if (first_load < 0) first_load = cyc;
        end
        ng = $countones({agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, agu_get_rd_noincr_o});
        if (ng != 0 || vrf_req_o || vrf_we_o) begin
          check("get_vs_req", {ng[3:0], vrf_req_o, agu_get_rd_noincr_o, vrf_we_o && !vrf_req_o},
                {4'd1, 1'b1, 1'b0, 1'b0});
        end
        if (vrf_req_o) begin
          req_cnt++;
          if (first_req < 0) first_req = cyc;
          strobe_at[cyc % 4096] = agu_get_rs1_o ? 2'd1 : agu_get_rs2_o ? 2'd2 : 2'd3;
        end
        if (agu_get_rs2_o) begin
          rs2_cnt++;
          check("rs2_only_when_two_src", cur_two_src, 1);
        end
        if (op_valid_o) begin
          if (exp_op_q.size() == 0) check("op_unexpected", 1, 0);
          else begin
            check("op_ab", {op_a_o, op_b_o}, exp_op_q[0]);
            if (op_ready_i) void'(exp_op_q.pop_front());
          end
        end
        if (vrf_req_o && vrf_we_o) begin
          wr_cnt++;
          check("write_in_res_valid", {agu_get_rd_o, res_valid_i, res_ready_o}, 3'b111);
          if (exp_q.size() == 0) check("write_unexpected", 1, 0);
          else check("write", {AW'(rd_p), vrf_wdata_o}, exp_q.pop_front());
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_writes_drained", exp_q.size(), 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int vl, input bit two, input bit fixed);
    logic [DW-1:0] a, b;
    rs1_base = $urandom_range(0, 255);
    rs2_base = 512 + $urandom_range(0, 255);
    rd_base  = 1024 + $urandom_range(0, 255);
    cur_two_src = two;
    for (int i = 0; i < vl; i++) begin
      mem[rs1_base + i] = fixed ? DW'(32'h11 * (i + 1)) : DW'($urandom);
      mem[rs2_base + i] = $urandom;
      a = mem[rs1_base + i];
      b = two ? mem[rs2_base + i] : '0;
      exp_op_q.push_back({a, b});
      exp_q.push_back({AW'(rd_base + i), alu_f(a, b)});
    end
    @(posedge clk_i); #1;
    vinstr_valid_i = 1'b1; vl_i = VW'(vl); two_src_i = two;
    @(posedge clk_i); #1;
    vinstr_valid_i = 1'b0; vl_i = VW'($urandom); two_src_i = $urandom_range(0, 1);
  endtask

  task automatic wait_done(input int start);
    bit got;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk_i);
      if (done_cnt > start) got = 1;
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  function automatic logic [10:0] ctl_vec();
    return {vinstr_ready_o, agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o,
            agu_get_rd_noincr_o, vrf_req_o, vrf_we_o, op_valid_o, res_ready_o, done_o};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, ctl_vec(), 11'b100_0000_0000);
    check({tag, "_state"}, dbg_state_o, VS_IDLE);
    check({tag, "_ops"}, {op_a_o, op_b_o}, 64'd0);
    check({tag, "_wdata"}, vrf_wdata_o, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int d0, vl;
    logic [1:0] pat [0:3];
    done_cnt = 0;
    clear_log();
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    // vl=3 two-source, zero-wait handshakes
    op_delay = 0; res_delay = 0;
    clear_log(); d0 = done_cnt;
    issue(3, 1, 0);
    wait_done(d0);
    check("t2_load_cycle", first_load - acc_cyc, 1);
    check("t2_first_read", first_req - acc_cyc, 5);
    check("t2_write_count", wr_cnt, 3);
    check("t2_load_count", load_cnt, 1);
    check("t2_done_cycle", done_cyc - acc_cyc, 17);
    pat[0] = 2'd1; pat[1] = 2'd2; pat[2] = 2'd0; pat[3] = 2'd3;
    for (int i = 0; i < 12; i++) check("t2_strobe_pattern", strobe_at[(acc_cyc + 5 + i) % 4096], pat[i % 4]);
`ifdef VCE2_VRF_SEQ_PERF_EN
    @(negedge clk_i);
    check("perf_words", perf_words_o, 3);
    check("perf_busy", perf_busy_o, 17);
`endif

    // vl=2 single-source with 0x11, 0x22
    clear_log(); d0 = done_cnt;
    issue(2, 0, 1);
    wait_done(d0);
    check("t3_rs2_count", rs2_cnt, 0);
    check("t3_write_count", wr_cnt, 2);
    check("t3_done_cycle", done_cyc - acc_cyc, 11);

    // vl=0
    clear_log(); d0 = done_cnt;
    issue(0, 1, 0);
    wait_done(d0);
    check("t4_no_load", load_cnt, 0);
    check("t4_no_req", req_cnt, 0);
    check("t4_done_latency_ok", (done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2), 1);

    // slow ALU: op_ready after 5 cycles, result after 3
    op_delay = 5; res_delay = 3;
    clear_log(); d0 = done_cnt;
    issue(1, 1, 0);
    wait_done(d0);
    check("t5_write_count", wr_cnt, 1);

    // reset while in RES
    op_delay = 0; res_delay = 3;
    clear_log(); d0 = done_cnt;
    issue(3, 1, 0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk_i);
        if (dbg_state_o == VS_RES) seen = 1;
      end
      check("t6_reached_res", seen, 1);
    end
    rst_ni = 1'b0;
    exp_q.delete(); exp_op_q.delete();
    #1 check_reset_outputs("t6_async");
    @(posedge clk_i); #1 check_reset_outputs("t6_held");
    @(negedge clk_i);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    res_delay = 0;
    clear_log(); d0 = done_cnt;
    issue(1, 1, 0);
    wait_done(d0);
    check("t6_after_reset_writes", wr_cnt, 1);
    check("t6_after_reset_done", done_cyc - acc_cyc, 9);

    // longest vector, single source
    clear_log(); d0 = done_cnt;
    issue(255, 0, 0);
    wait_done(d0);
    check("t7_vlmax_writes", wr_cnt, 255);
    check("t7_vlmax_done", done_cyc - acc_cyc, 5 + 3 * 255);

    // randomized instructions and handshake delays
    for (int n = 0; n < 30; n++) begin
      op_delay = $urandom_range(0, 3);
      res_delay = $urandom_range(0, 3);
      vl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      clear_log(); d0 = done_cnt;
      issue(vl, $urandom_range(0, 1), 0);
      wait_done(d0);
      check("rand_write_count", wr_cnt, vl);
    end

    repeat (4) @(posedge clk_i);
    check("final_exp_writes_empty", exp_q.size(), 0);
    check("final_exp_ops_empty", exp_op_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
